// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling, 3-sample majority vote,
// false-start rejection and break/idle re-arm.
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              RxD,
    input  logic              Rx_EN,
    input  logic [2:0]        baud_select,
    output logic [DATA_W-1:0] Rx_DATA,
    output logic              Rx_VALID,
    output logic              Rx_PERROR,
    output logic              Rx_FERROR,
    output logic              Rx_BUSY
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, WAIT_HI
    } state_t;

    function automatic int div_of(input int baud);
        return (CLK_FREQ + 8 * baud) / (16 * baud);
    endfunction

    localparam int CW = $clog2(div_of(300) + 1);

    state_t            state_q, state_d;
    logic              sync_q, rxs_q, rxs_prev_q;
    logic [2:0]        baud_q, baud_d;
    logic [CW-1:0]     div_cnt_q, div_cnt_d, div_m1;
    logic [3:0]        tick_cnt_q, tick_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              s7_q, s7_d, s8_q, s8_d;
    logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
    logic              par_q, par_d, serr_q, serr_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              tick, dec, maj, fall, start_det;
    logic              last_data, last_stop, frame_end, exp_par;

    always_comb begin
        case (baud_q)
            3'd0:    div_m1 = CW'(div_of(300) - 1);
            3'd1:    div_m1 = CW'(div_of(1200) - 1);
            3'd2:    div_m1 = CW'(div_of(4800) - 1);
            3'd3:    div_m1 = CW'(div_of(9600) - 1);
            3'd4:    div_m1 = CW'(div_of(19200) - 1);
            3'd5:    div_m1 = CW'(div_of(38400) - 1);
            3'd6:    div_m1 = CW'(div_of(57600) - 1);
            default: div_m1 = CW'(div_of(115200) - 1);
        endcase
    end

    assign tick      = (div_cnt_q == div_m1);
    assign dec       = tick && (tick_cnt_q == 4'd9);
    assign maj       = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
    assign fall      = rxs_prev_q & ~rxs_q;
    assign start_det = Rx_EN && (state_q == IDLE) && fall;
    assign last_data = (bit_cnt_q == 4'(DATA_W - 1));
    assign last_stop = (bit_cnt_q == 4'(STOP_BITS - 1));

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!Rx_EN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_det) state_d = START;
                START:   if (dec) state_d = maj ? IDLE : DATA;
                DATA:    if (dec && last_data)
                             state_d = (PARITY != 0) ? PAR : STOP;
                PAR:     if (dec) state_d = STOP;
                STOP:    if (dec && last_stop)
                             state_d = rxs_q ? IDLE : WAIT_HI;
                WAIT_HI: if (tick && rxs_q && tick_cnt_q == 4'd15)
                             state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        Rx_BUSY   = (state_q == START) || (state_q == DATA) ||
                    (state_q == PAR)   || (state_q == STOP);
        frame_end = Rx_EN && (state_q == STOP) && dec && last_stop;
        exp_par   = (PARITY == 2) ? ~^sh_q : ^sh_q;
        perr_d    = frame_end && (PARITY != 0) && (par_q != exp_par);
        ferr_d    = frame_end && (serr_q || !maj);
        valid_d   = frame_end && !perr_d && !ferr_d;
        data_d    = valid_d ? sh_q : data_q;
    end

    always_comb begin
        baud_d     = baud_q;
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        tick_cnt_d = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        s7_d       = (tick && tick_cnt_q == 4'd7) ? rxs_q : s7_q;
        s8_d       = (tick && tick_cnt_q == 4'd8) ? rxs_q : s8_q;
        sh_d       = sh_q;
        par_d      = par_q;
        serr_d     = serr_q;
        // a full bit time of continuous high is needed to leave WAIT_HI
        if (state_q == WAIT_HI && !rxs_q) tick_cnt_d = '0;
        if (dec) begin
            case (state_q)
                DATA: begin
                    sh_d      = {maj, sh_q[DATA_W-1:1]};
                    bit_cnt_d = last_data ? '0 : bit_cnt_q + 1'b1;
                end
                PAR:  par_d = maj;
                STOP: begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (!maj) serr_d = 1'b1;
                end
                default: ;
            endcase
        end
        if (start_det) begin
            baud_d     = baud_select;
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            serr_d     = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            baud_q     <= '0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            sh_q       <= '0;
            par_q      <= 1'b0;
            serr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= RxD;
            rxs_q      <= sync_q;
            rxs_prev_q <= rxs_q;
            baud_q     <= baud_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            serr_q     <= serr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8E1 @115200/50 MHz and
// 7O2 @9600 on a 1.8432 MHz-parameterised instance.
module tb_uart_rx_param;

    localparam int BIT_A = 16 * 27;
    localparam int BIT_B = 16 * 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic       sel_b = 1'b0;
    logic       rx_en = 1'b1;
    logic       rxd_a, rxd_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       v_a, p_a, f_a, busy_a;
    logic       v_b, p_b, f_b, busy_b;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int nv_a = 0, np_a = 0, nf_a = 0, lat_a = 0;
    int nv_b = 0, np_b = 0, nf_b = 0;

    assign rxd_a = sel_b ? 1'b1 : rx_line;
    assign rxd_b = sel_b ? rx_line : 1'b1;

    always #10 clk = ~clk;

    uart_rx_param dut_a (
        .Clk(clk), .reset(rst_n), .RxD(rxd_a), .Rx_EN(rx_en),
        .baud_select(3'b111), .Rx_DATA(data_a), .Rx_VALID(v_a),
        .Rx_PERROR(p_a), .Rx_FERROR(f_a), .Rx_BUSY(busy_a)
    );

    uart_rx_param #(
        .CLK_FREQ(1_843_200), .DATA_W(7), .PARITY(2), .STOP_BITS(2)
    ) dut_b (
        .Clk(clk), .reset(rst_n), .RxD(rxd_b), .Rx_EN(rx_en),
        .baud_select(3'b011), .Rx_DATA(data_b), .Rx_VALID(v_b),
        .Rx_PERROR(p_b), .Rx_FERROR(f_b), .Rx_BUSY(busy_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v_a) begin nv_a++; lat_a = cyc; end
        if (p_a) np_a++;
        if (f_a) nf_a++;
        if (v_b) nv_b++;
        if (p_b) np_b++;
        if (f_b) nf_b++;
    end

    typedef struct {
        logic [8:0] d;
        bit         flip;
        logic [1:0] stops;
        int         ev, ep, ef;
        logic [8:0] edata;
    } vec_t;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits,
                              input int pmode, input bit flip,
                              input logic [1:0] stops, input int nstop,
                              input int bitc, input logic end_lvl);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p ^= d[i];
        if (pmode == 2) p = ~p;
        if (flip) p = ~p;
        rx_line = 1'b0;
        wait_clk(bitc);
        for (int i = 0; i < nbits; i++) begin
            rx_line = d[i];
            wait_clk(bitc);
        end
        if (pmode != 0) begin
            rx_line = p;
            wait_clk(bitc);
        end
        for (int i = 0; i < nstop; i++) begin
            rx_line = stops[i];
            wait_clk(bitc);
        end
        rx_line = end_lvl;
    endtask

    initial begin
        vec_t vt[5];
        int   bv, bp, bf, t0;
        vt[0] = '{9'h0A5, 1'b0, 2'b11, 1, 0, 0, 9'h0A5};
        vt[1] = '{9'h03C, 1'b1, 2'b11, 0, 1, 0, 9'h0A5};
        vt[2] = '{9'h000, 1'b0, 2'b11, 1, 0, 0, 9'h000};
        vt[3] = '{9'h06E, 1'b1, 2'b00, 0, 1, 1, 9'h000};
        vt[4] = '{9'h0FF, 1'b0, 2'b11, 1, 0, 0, 9'h0FF};

        wait_clk(4);
        check("reset_a", int'({data_a, v_a, p_a, f_a, busy_a}), 0);
        check("reset_b", int'({data_b, v_b, p_b, f_b, busy_b}), 0);
        rst_n = 1'b1;
        wait_clk(BIT_A);

        for (int i = 0; i < 5; i++) begin
            bv = nv_a; bp = np_a; bf = nf_a;
            t0 = cyc;
            send_frame(vt[i].d, 8, 1, vt[i].flip, vt[i].stops, 1,
                       BIT_A, 1'b1);
            wait_clk(2 * BIT_A);
            check($sformatf("v%0d_valid", i), nv_a - bv, vt[i].ev);
            check($sformatf("v%0d_perr", i), np_a - bp, vt[i].ep);
            check($sformatf("v%0d_ferr", i), nf_a - bf, vt[i].ef);
            check($sformatf("v%0d_data", i), int'(data_a),
                  int'(vt[i].edata));
            if (i == 0) check("latency", lat_a - t0, 4593);
        end

        // stop bit low, then a 20-bit break
        bv = nv_a; bp = np_a; bf = nf_a;
        send_frame(9'h081, 8, 1, 1'b0, 2'b00, 1, BIT_A, 1'b0);
        wait_clk(20 * BIT_A);
        check("brk_ferr", nf_a - bf, 1);
        check("brk_valid", nv_a - bv, 0);
        check("brk_perr", np_a - bp, 0);
        check("brk_busy", int'(busy_a), 0);
        rx_line = 1'b1;
        wait_clk(BIT_A / 2);
        rx_line = 1'b0;
        wait_clk(BIT_A);
        check("wait_hi_busy", int'(busy_a), 0);
        wait_clk(BIT_A);
        rx_line = 1'b1;
        wait_clk(2 * BIT_A);
        check("wait_hi_ferr", nf_a - bf, 1);
        check("wait_hi_valid", nv_a - bv, 0);
        send_frame(9'h055, 8, 1, 1'b0, 2'b11, 1, BIT_A, 1'b1);
        wait_clk(2 * BIT_A);
        check("rearm_valid", nv_a - bv, 1);
        check("rearm_data", int'(data_a), 8'h55);

        // false start: 4 sample ticks low
        bv = nv_a; bp = np_a; bf = nf_a;
        rx_line = 1'b0;
        wait_clk(54);
        check("glitch_busy_early", int'(busy_a), 1);
        wait_clk(54);
        rx_line = 1'b1;
        wait_clk(BIT_A);
        check("glitch_busy_late", int'(busy_a), 0);
        check("glitch_pulses", (nv_a - bv) + (np_a - bp) + (nf_a - bf), 0);

        // enable dropped in bit 3 of 0xFF
        rx_line = 1'b0;
        wait_clk(BIT_A);
        rx_line = 1'b1;
        wait_clk(3 * BIT_A + BIT_A / 2);
        rx_en = 1'b0;
        wait_clk(2);
        check("abort_busy", int'(busy_a), 0);
        wait_clk(8 * BIT_A);
        rx_en = 1'b1;
        wait_clk(BIT_A);
        check("abort_pulses", (nv_a - bv) + (np_a - bp) + (nf_a - bf), 0);
        check("abort_hold", int'(data_a), 8'h55);
        send_frame(9'h012, 8, 1, 1'b0, 2'b11, 1, BIT_A, 1'b1);
        wait_clk(2 * BIT_A);
        check("abort_next_valid", nv_a - bv, 1);
        check("abort_next_data", int'(data_a), 8'h12);

        // 7O2 instance: back-to-back frames
        sel_b = 1'b1;
        wait_clk(3 * BIT_B);
        bv = nv_b; bp = np_b; bf = nf_b;
        for (int i = 0; i < 3; i++)
            send_frame(9'h07F, 7, 2, 1'b0, 2'b11, 2, BIT_B, 1'b1);
        wait_clk(2 * BIT_B);
        check("b2b_valid", nv_b - bv, 3);
        check("b2b_perr", np_b - bp, 0);
        check("b2b_ferr", nf_b - bf, 0);
        check("b2b_data", int'(data_b), 7'h7F);

        bv = nv_b; bp = np_b; bf = nf_b;
        send_frame(9'h005, 7, 2, 1'b0, 2'b01, 2, BIT_B, 1'b1);
        wait_clk(3 * BIT_B);
        check("stop2_ferr", nf_b - bf, 1);
        check("stop2_valid", nv_b - bv, 0);
        check("stop2_perr", np_b - bp, 0);
        check("stop2_data", int'(data_b), 7'h7F);

        // reset mid-frame
        rx_line = 1'b0;
        wait_clk(BIT_B);
        rx_line = 1'b1;
        wait_clk(BIT_B);
        check("mid_busy", int'(busy_b), 1);
        bv = nv_b; bp = np_b; bf = nf_b;
        rst_n = 1'b0;
        #1;
        check("rst_mid_b", int'({data_b, v_b, p_b, f_b, busy_b}), 0);
        check("rst_mid_a", int'({data_a, v_a, p_a, f_a, busy_a}), 0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(8 * BIT_B);
        check("rst_no_flag", (nv_b - bv) + (np_b - bp) + (nf_b - bf), 0);
        send_frame(9'h02A, 7, 2, 1'b0, 2'b11, 2, BIT_B, 1'b1);
        wait_clk(2 * BIT_B);
        check("post_rst_valid", nv_b - bv, 1);
        check("post_rst_data", int'(data_b), 7'h2A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
